// File: rtl/nco_phase_sequencer_if.sv
// Bundles the control, sine-stage handshake and sample-stream signals of nco_phase_sequencer.
// The master modport is the sequencer's view; slave is the view of the surrounding logic.
interface nco_phase_sequencer_if;
  logic        enable;
  logic        phase_clr;
  logic [17:0] phase_inc;
  logic        sample_tick;
  logic        cordic_update;
  logic [17:0] cordic_angle;
  logic        cordic_ready;
  logic [15:0] cordic_sine;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;

  modport master (
    input  enable, phase_clr, phase_inc, sample_tick, cordic_ready, cordic_sine,
    output cordic_update, cordic_angle, sample_out, sample_valid, busy, overrun, timeout
  );

  modport slave (
    output enable, phase_clr, phase_inc, sample_tick, cordic_ready, cordic_sine,
    input  cordic_update, cordic_angle, sample_out, sample_valid, busy, overrun, timeout
  );
endinterface

// File: rtl/nco_phase_sequencer.sv
// NCO phase sequencer: paces the CORDIC sine stage from sample ticks and advances phase mod 2*pi.
// Define NCO_TIMEOUT_EN to abort a conversion whose ready handshake never returns.
module nco_phase_sequencer #(
  parameter int TWO_PI = 102944
`ifdef NCO_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  nco_phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    CAPTURE
  } state_e;

  localparam logic [18:0] TwoPi  = 19'(TWO_PI);
  localparam logic [17:0] IncMax = 18'(TWO_PI - 1);

  state_e      state_q, state_d;
  logic [17:0] phase_q, phase_d;
  logic [17:0] angle_q, angle_d;
  logic [15:0] sample_q, sample_d;
  logic        overrun_q, overrun_d;

  logic [17:0] incSat;
  logic [18:0] sum;
  logic [17:0] wrapped;

`ifdef NCO_TIMEOUT_EN
  localparam int            CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Step is built from the held launch angle, so a phase_clr launch restarts the sequence from 0.
  always_comb begin
    incSat  = (bus.phase_inc > IncMax) ? IncMax : bus.phase_inc;
    sum     = {1'b0, angle_q} + {1'b0, incSat};
    wrapped = (sum >= TwoPi) ? 18'(sum - TwoPi) : sum[17:0];
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    angle_d   = angle_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;
`ifdef NCO_TIMEOUT_EN
    waitCnt_d = '0;
    timeout_d = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.sample_tick && bus.enable) begin
          state_d = LAUNCH;
          angle_d = bus.phase_clr ? '0 : phase_q;
        end
      end
      LAUNCH:  state_d = WAIT_LO;
      // Ready is still high from the previous result right after the update pulse.
      WAIT_LO: if (!bus.cordic_ready) state_d = WAIT_HI;
      WAIT_HI: begin
        if (bus.cordic_ready) begin
          state_d  = CAPTURE;
          sample_d = bus.cordic_sine;
        end
      end
      CAPTURE: begin
        phase_d = wrapped;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!bus.enable) begin
      overrun_d = 1'b0;
    end else if (bus.sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

`ifdef NCO_TIMEOUT_EN
    if (!bus.enable) timeout_d = 1'b0;
    if ((state_q == WAIT_LO) || (state_q == WAIT_HI)) begin
      waitCnt_d = waitCnt_q + CntW'(1);
      if ((state_d != CAPTURE) && (waitCnt_q == CntLast)) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      angle_q   <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
`ifdef NCO_TIMEOUT_EN
      waitCnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      angle_q   <= angle_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
`ifdef NCO_TIMEOUT_EN
      waitCnt_q <= waitCnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.cordic_update = (state_q == LAUNCH);
  assign bus.cordic_angle  = angle_q;
  assign bus.sample_out    = sample_q;
  assign bus.sample_valid  = (state_q == CAPTURE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.overrun       = overrun_q;
`ifdef NCO_TIMEOUT_EN
  assign bus.timeout       = timeout_q;
`else
  assign bus.timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_nco_phase_sequencer.sv
// Directed bench for nco_phase_sequencer with a behavioural CORDIC handshake model
// (stale ready for one cycle after update, then low for 'latency' cycles).
module tb_nco_phase_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  nco_phase_sequencer_if bus ();

  nco_phase_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int latency = 3;
  bit stuck   = 1'b0;

  logic [17:0] mAngle;
  int          mCnt;
  logic        mStale;
  logic        mPend;

  // Reference sine stage: quarter-turn angles return sin*2^15, anything else a fixed scramble.
  function automatic logic [15:0] sineOf(input logic [17:0] a);
    case (a)
      18'd0:     return 16'd0;
      18'd25736: return 16'd32767;
      18'd51472: return 16'd0;
      18'd77208: return 16'h8001;
      default:   return 16'(a ^ 18'h15A5A);
    endcase
  endfunction

  // CORDIC model: ready stays high one cycle after update, drops for 'latency' cycles, then rises with the result.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cordic_ready <= 1'b1;
      bus.cordic_sine  <= '0;
      mPend            <= 1'b0;
      mStale           <= 1'b0;
      mCnt             <= 0;
      mAngle           <= '0;
    end else if (bus.cordic_update) begin
      mPend  <= 1'b1;
      mStale <= 1'b1;
      mAngle <= bus.cordic_angle;
    end else if (mPend) begin
      if (mStale) begin
        mStale           <= 1'b0;
        bus.cordic_ready <= 1'b0;
        mCnt             <= latency;
      end else if (!stuck) begin
        if (mCnt > 1) begin
          mCnt <= mCnt - 1;
        end else begin
          bus.cordic_ready <= 1'b1;
          bus.cordic_sine  <= sineOf(mAngle);
          mPend            <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [17:0] inc);
    bus.enable    = en;
    bus.phase_inc = inc;
  endtask

  // Launches one conversion from a negedge and follows it to the sample_valid pulse.
  task automatic convert(input string tag, input logic clr, input logic [17:0] expAngle,
                         input logic [15:0] expSine, input int tickAt);
    int   cyc        = 0;
    int   extraUpd   = 0;
    int   angleMoves = 0;
    logic r1, r2;
    bus.phase_clr   = clr;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.phase_clr   = 1'b0;
    checkOutput({tag, " update"}, 32'(bus.cordic_update), 32'd1);
    checkOutput({tag, " angle"}, 32'(bus.cordic_angle), 32'(expAngle));
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    r2 = 1'b1;
    r1 = bus.cordic_ready;
    do begin
      bus.sample_tick = (cyc == tickAt);
      @(negedge clk);
      cyc++;
      if (bus.cordic_update) extraUpd++;
      if (bus.cordic_angle != expAngle) angleMoves++;
      if (!bus.sample_valid) begin
        r2 = r1;
        r1 = bus.cordic_ready;
      end
    end while (!bus.sample_valid && cyc < 200);
    bus.sample_tick = 1'b0;
    checkOutput({tag, " valid"}, 32'(bus.sample_valid), 32'd1);
    checkOutput({tag, " sample"}, 32'(bus.sample_out), 32'(expSine));
    checkOutput({tag, " single update"}, 32'(extraUpd), 32'd0);
    checkOutput({tag, " angle held"}, 32'(angleMoves), 32'd0);
    checkOutput({tag, " ready high before capture"}, 32'(r1), 32'd1);
    checkOutput({tag, " ready low two before capture"}, 32'(r2), 32'd0);
    @(negedge clk);
    checkOutput({tag, " valid drops"}, 32'(bus.sample_valid), 32'd0);
    checkOutput({tag, " busy drops"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seenValid;
    bus.sample_tick = 1'b0;
    bus.phase_clr   = 1'b0;
    applyStimulus(1'b0, 18'd0);

    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset update", 32'(bus.cordic_update), 32'd0);
    checkOutput("reset angle", 32'(bus.cordic_angle), 32'd0);
    checkOutput("reset sample", 32'(bus.sample_out), 32'd0);
    checkOutput("reset valid", 32'(bus.sample_valid), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset overrun", 32'(bus.overrun), 32'd0);
    checkOutput("reset timeout", 32'(bus.timeout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] pi/2 stepping");
    applyStimulus(1'b1, 18'd25736);
    convert("quarter0", 1'b0, 18'd0, 16'd0, -1);
    convert("quarter1", 1'b0, 18'd25736, 16'd32767, -1);
    convert("quarter2", 1'b0, 18'd51472, 16'd0, -1);
    convert("quarter3", 1'b0, 18'd77208, 16'h8001, -1);
    convert("quarter4", 1'b0, 18'd0, 16'd0, -1);
    checkOutput("no overrun after steps", 32'(bus.overrun), 32'd0);

    $display("[TB] wrap and saturation");
    applyStimulus(1'b1, 18'd100000);
    convert("clear launch", 1'b1, 18'd0, 16'd0, -1);
    applyStimulus(1'b1, 18'd5000);
    convert("preloaded", 1'b0, 18'd100000, sineOf(18'd100000), -1);
    applyStimulus(1'b1, 18'd200000);
    convert("wrapped", 1'b0, 18'd2056, sineOf(18'd2056), -1);
    convert("saturated", 1'b0, 18'd2055, sineOf(18'd2055), -1);

    $display("[TB] stale ready handshake");
    applyStimulus(1'b1, 18'd1000);
    latency = 18;
    convert("stale", 1'b0, 18'd2054, sineOf(18'd2054), -1);

    $display("[TB] overrun");
    convert("overrun", 1'b0, 18'd3054, sineOf(18'd3054), 5);
    checkOutput("overrun set", 32'(bus.overrun), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("overrun sticky", 32'(bus.overrun), 32'd1);
    applyStimulus(1'b0, 18'd1000);
    @(negedge clk);
    checkOutput("overrun cleared", 32'(bus.overrun), 32'd0);
    applyStimulus(1'b1, 18'd1000);
    @(negedge clk);

    $display("[TB] async reset mid-wait");
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    checkOutput("pre-reset angle", 32'(bus.cordic_angle), 32'd4054);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async busy", 32'(bus.busy), 32'd0);
    checkOutput("async angle", 32'(bus.cordic_angle), 32'd0);
    checkOutput("async update", 32'(bus.cordic_update), 32'd0);
    checkOutput("async valid", 32'(bus.sample_valid), 32'd0);
    checkOutput("async sample", 32'(bus.sample_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    latency = 3;
    @(negedge clk);
    convert("post-reset", 1'b0, 18'd0, 16'd0, -1);

    $display("[TB] ready stuck low");
    stuck = 1'b1;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    checkOutput("stuck angle", 32'(bus.cordic_angle), 32'd1000);
    seenValid = 1'b0;
`ifdef NCO_TIMEOUT_EN
    repeat (70) begin
      @(negedge clk);
      if (bus.sample_valid) seenValid = 1'b1;
    end
    checkOutput("timeout set", 32'(bus.timeout), 32'd1);
    checkOutput("timeout idle", 32'(bus.busy), 32'd0);
    checkOutput("timeout no valid", 32'(seenValid), 32'd0);
    stuck = 1'b0;
    repeat (10) @(negedge clk);
    convert("after timeout", 1'b0, 18'd1000, sineOf(18'd1000), -1);
    applyStimulus(1'b0, 18'd1000);
    @(negedge clk);
    checkOutput("timeout cleared", 32'(bus.timeout), 32'd0);
    applyStimulus(1'b1, 18'd1000);
`else
    repeat (100) begin
      @(negedge clk);
      if (bus.sample_valid) seenValid = 1'b1;
    end
    checkOutput("stuck busy", 32'(bus.busy), 32'd1);
    checkOutput("stuck timeout", 32'(bus.timeout), 32'd0);
    checkOutput("stuck no valid", 32'(seenValid), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    checkOutput("stuck recovered", 32'(bus.busy), 32'd0);
`endif
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_phase_sequencer.md
Name: nco_phase_sequencer

Overview:
- Upstream driver for the CORDIC sine stage.
- Holds an 18-bit phase accumulator in the team's fixed-point radian format, with angle = rad * 2^FIX_SHIFT.
- On each sample strobe it presents the current phase, pulses the sine stage's update input, and waits through the ready handshake.
- It then captures the 16-bit signed sine result and advances the phase modulo 2*pi, so downstream logic receives a paced sine sample stream.

Parameters:
- TWO_PI, 102944, 2*pi in fixed point (4 * PI2 at FIX_SHIFT=14); phase wrap modulus.
- TIMEOUT, 64, max cycles to wait for cordic_ready (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new conversions.
- phase_clr  in  1  sync; forces phase to 0 at the next launch.
- phase_inc  in  18  per-sample phase step, unsigned.
- sample_tick  in  1  one-cycle sample-rate strobe.
- cordic_update  out  1  one-cycle start pulse to the sine stage.
- cordic_angle  out  18  angle to the sine stage.
- cordic_ready  in  1  sine stage done/result-valid level.
- cordic_sine  in  16  signed sine result from the sine stage.
- sample_out  out  16  last captured sine sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high from launch through capture.
- overrun  out  1  sticky: a tick was dropped while busy.
- timeout  out  1  sticky: ready never returned (optional feature only; else tied 0).

Behaviour:
- Reset (async, all registers): phase=0, state=IDLE. All outputs are 0 at reset: cordic_update, cordic_angle, sample_out, sample_valid, busy, overrun, timeout.
- States: IDLE, LAUNCH, WAIT_LO, WAIT_HI, CAPTURE.
- IDLE:
  - On sample_tick & enable, go to LAUNCH.
  - Register cordic_angle = phase_clr ? 0 : phase.
- LAUNCH (1 cycle): cordic_update=1, busy=1, then go to WAIT_LO.
- WAIT_LO:
  - Wait for cordic_ready=0. The sine stage still shows ready for the cycle after update is sampled, so this state ignores it.
  - On ready=0, go to WAIT_HI.
- WAIT_HI: on cordic_ready=1, go to CAPTURE.
- CAPTURE (1 cycle):
  - sample_out <= cordic_sine; sample_valid=1.
  - phase <= wrap(cordic_angle + sat(phase_inc)).
  - Go to IDLE; busy drops the cycle after.
- cordic_angle is held constant from LAUNCH through CAPTURE. The sine stage derives quadrant and target combinationally from its angle input, so it must not change mid-compute.
- Phase arithmetic:
  - sat(x) = min(x, TWO_PI-1).
  - sum is 19-bit; wrap(sum) = sum >= TWO_PI ? sum - TWO_PI : sum.
  - Phase is always in [0, TWO_PI).
- Latency: tick to cordic_update = 1 cycle. Ready-high observed to sample_valid = 1 cycle.
- sample_tick while busy (LAUNCH..CAPTURE): tick dropped, overrun <= 1. A tick in the same cycle the FSM returns to IDLE is accepted.
- overrun and timeout clear only on reset or on enable=0.
- enable falling mid-conversion: the conversion completes and captures normally; no new launch.
- phase_inc changes mid-conversion: the value sampled in CAPTURE is used.

Optional Feature:
- NCO_TIMEOUT_EN defined:
  - A counter runs in WAIT_LO/WAIT_HI.
  - If it reaches TIMEOUT cycles without reaching CAPTURE: go to IDLE, timeout <= 1, no sample_valid, phase not advanced.
- Undefined: no counter; the FSM waits indefinitely; timeout output is constant 0.

Test Plan:
- π/2 stepping: phase_inc=25736, 5 ticks, model sine returning sin*2^15.
  - cordic_angle sequence is 0, 25736, 51472, 77208, 0 (102944 wraps to 0).
  - sample_valid pulses 5 times; sample_out ≈ 0, +32767, 0, -32767, 0.
- Wrap arithmetic: preload phase to 100000 via steps, phase_inc=5000, then tick.
  - Next cordic_angle = 2056.
  - phase_inc=200000 saturates to 102943, so the next angle is (a + 102943) mod 102944.
- Handshake stale-ready: model keeps ready=1 for 1 cycle after update, then 0 for 18 cycles, then 1.
  - No capture on the stale ready.
  - Capture exactly 1 cycle after the ready rise.
  - cordic_angle is stable throughout.
- Overrun: second sample_tick during WAIT_HI.
  - Only one cordic_update; overrun=1 and stays 1.
  - enable=0 for 1 cycle clears it.
- Async reset asserted mid-WAIT_HI, between clock edges: all outputs 0 immediately; phase=0; the next tick launches angle 0.
- With NCO_TIMEOUT_EN, TIMEOUT=64, ready stuck 0:
  - timeout=1 after 64 wait cycles; no sample_valid; phase unchanged.
  - Without the macro, busy stays 1.
